// File: rtl/ac_scan_ctrl.sv
// Aho-Corasick scan sequencer: walks goto/failure/accept RAMs once per input character
// and emits one (state, match, position) result per character.
module ac_scan_ctrl #(
  parameter int unsigned          STATE_W   = 8,
  parameter int unsigned          CHAR_W    = 4,
  parameter logic [STATE_W-1:0]   FAIL_CODE = 8'hFF,
  parameter int unsigned          MAX_FAIL  = 16,
  parameter int unsigned          POS_W     = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      CHARA_VALID,
  input  logic [CHAR_W-1:0]         CHARA,
  output logic                      CHARA_READY,
  output logic [STATE_W+CHAR_W-1:0] ADDR_G,
  output logic                      GOTO_RE,
  input  logic [STATE_W-1:0]        GOTO_DATA,
  output logic [STATE_W-1:0]        ADDR_F,
  output logic                      FAIL_RE,
  input  logic [STATE_W-1:0]        FAIL_DATA,
  output logic [STATE_W-1:0]        ACC_ADDR,
  output logic                      ACC_RE,
  input  logic                      ACC_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [STATE_W-1:0]        NOW_STATE,
  output logic                      MATCH,
  output logic [POS_W-1:0]          POS,
  output logic                      FAIL_ERR
);

  localparam int unsigned HOP_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GREQ, S_GWAIT, S_FREQ, S_FWAIT, S_AREQ, S_AWAIT, S_EMIT
  } fsm_t;

  fsm_t                      fsm_q, fsm_d;
  logic [STATE_W-1:0]        st_q, st_d;
  logic [CHAR_W-1:0]         chr_q, chr_d;
  logic [HOP_W-1:0]          hop_q, hop_d;
  logic [STATE_W+CHAR_W-1:0] addr_g_q, addr_g_d;
  logic                      goto_re_q, goto_re_d;
  logic [STATE_W-1:0]        addr_f_q, addr_f_d;
  logic                      fail_re_q, fail_re_d;
  logic [STATE_W-1:0]        acc_addr_q, acc_addr_d;
  logic                      acc_re_q, acc_re_d;
  logic [STATE_W-1:0]        now_state_q, now_state_d;
  logic                      match_q, match_d;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic                      out_valid_q, out_valid_d;
  logic                      fail_err_q, fail_err_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q       <= S_IDLE;
      st_q        <= '0;
      chr_q       <= '0;
      hop_q       <= '0;
      addr_g_q    <= '0;
      goto_re_q   <= 1'b0;
      addr_f_q    <= '0;
      fail_re_q   <= 1'b0;
      acc_addr_q  <= '0;
      acc_re_q    <= 1'b0;
      now_state_q <= '0;
      match_q     <= 1'b0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      fail_err_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      st_q        <= st_d;
      chr_q       <= chr_d;
      hop_q       <= hop_d;
      addr_g_q    <= addr_g_d;
      goto_re_q   <= goto_re_d;
      addr_f_q    <= addr_f_d;
      fail_re_q   <= fail_re_d;
      acc_addr_q  <= acc_addr_d;
      acc_re_q    <= acc_re_d;
      now_state_q <= now_state_d;
      match_q     <= match_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      fail_err_q  <= fail_err_d;
    end
  end

  // Strobes and addresses are registered on entry to their *REQ state, so each
  // strobe is high exactly while the FSM sits in that request state.
  always_comb begin
    fsm_d       = fsm_q;
    st_d        = st_q;
    chr_d       = chr_q;
    hop_d       = hop_q;
    addr_g_d    = addr_g_q;
    goto_re_d   = 1'b0;
    addr_f_d    = addr_f_q;
    fail_re_d   = 1'b0;
    acc_addr_d  = acc_addr_q;
    acc_re_d    = 1'b0;
    now_state_d = now_state_q;
    match_d     = match_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    fail_err_d  = fail_err_q;
    case (fsm_q)
      S_IDLE: begin
        if (CHARA_VALID && EN) begin
          chr_d     = CHARA;
          hop_d     = '0;
          goto_re_d = 1'b1;
          addr_g_d  = {st_q, CHARA};
          fsm_d     = S_GREQ;
        end
      end
      S_GREQ: fsm_d = S_GWAIT;
      S_GWAIT: begin
        if (GOTO_DATA != FAIL_CODE || st_q == '0) begin
          st_d       = (GOTO_DATA != FAIL_CODE) ? GOTO_DATA : '0;
          acc_re_d   = 1'b1;
          acc_addr_d = st_d;
          fsm_d      = S_AREQ;
        end else begin
          fail_re_d = 1'b1;
          addr_f_d  = st_q;
          fsm_d     = S_FREQ;
        end
      end
      S_FREQ: fsm_d = S_FWAIT;
      S_FWAIT: begin
        hop_d = hop_q + 1'b1;
        // A chain this long means a broken table; give up and restart from root.
        if (hop_d == HOP_W'(MAX_FAIL)) begin
          fail_err_d = 1'b1;
          st_d       = '0;
        end else begin
          st_d = FAIL_DATA;
        end
        goto_re_d = 1'b1;
        addr_g_d  = {st_d, chr_q};
        fsm_d     = S_GREQ;
      end
      S_AREQ: fsm_d = S_AWAIT;
      S_AWAIT: begin
        match_d     = ACC_DATA;
        now_state_d = st_q;
        out_valid_d = 1'b1;
        fsm_d       = S_EMIT;
      end
      S_EMIT: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          pos_d       = pos_q + 1'b1;
          fsm_d       = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign CHARA_READY = (fsm_q == S_IDLE) && EN;
  assign ADDR_G      = addr_g_q;
  assign GOTO_RE     = goto_re_q;
  assign ADDR_F      = addr_f_q;
  assign FAIL_RE     = fail_re_q;
  assign ACC_ADDR    = acc_addr_q;
  assign ACC_RE      = acc_re_q;
  assign OUT_VALID   = out_valid_q;
  assign NOW_STATE   = now_state_q;
  assign MATCH       = match_q;
  assign POS         = pos_q;
  assign FAIL_ERR    = fail_err_q;

endmodule

// File: tb/tb_ac_scan_ctrl.sv
// Bench for ac_scan_ctrl: RAM models, a table-walking reference model, directed
// scenarios with literal expectations, then a randomized run.
module tb_ac_scan_ctrl;
  localparam int MAXF = 16;

  logic        CLK = 1'b0;
  logic        RST, EN, CHARA_VALID, CHARA_READY;
  logic [3:0]  CHARA;
  logic [11:0] ADDR_G;
  logic        GOTO_RE, FAIL_RE, ACC_RE, ACC_DATA;
  logic [7:0]  GOTO_DATA, ADDR_F, FAIL_DATA, ACC_ADDR, NOW_STATE;
  logic        OUT_VALID, OUT_READY, MATCH, FAIL_ERR;
  logic [15:0] POS;

  always #5 CLK = ~CLK;

  ac_scan_ctrl dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CHARA_VALID(CHARA_VALID), .CHARA(CHARA),
    .CHARA_READY(CHARA_READY), .ADDR_G(ADDR_G), .GOTO_RE(GOTO_RE), .GOTO_DATA(GOTO_DATA),
    .ADDR_F(ADDR_F), .FAIL_RE(FAIL_RE), .FAIL_DATA(FAIL_DATA), .ACC_ADDR(ACC_ADDR),
    .ACC_RE(ACC_RE), .ACC_DATA(ACC_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .NOW_STATE(NOW_STATE), .MATCH(MATCH), .POS(POS), .FAIL_ERR(FAIL_ERR)
  );

  logic [7:0] goto_tbl [0:4095];
  logic [7:0] fail_tbl [0:255];
  logic       acc_tbl  [0:255];

  // Synchronous-read RAMs: data appears the cycle after the strobe.
  always @(posedge CLK) begin
    if (GOTO_RE) GOTO_DATA <= goto_tbl[ADDR_G];
    if (FAIL_RE) FAIL_DATA <= fail_tbl[ADDR_F];
    if (ACC_RE)  ACC_DATA  <= acc_tbl[ACC_ADDR];
  end

  typedef struct {
    int st; int m; int pos; int lat; int err; int acc_cyc;
  } exp_t;
  exp_t expq[$];

  int errors = 0, checks = 0, cyc = 0;
  int m_state = 0, m_pos = 0, m_err = 0;
  int last_st, last_m, last_pos, last_lat, cur_lat;
  bit chk_on = 0, prev_ov = 0;
  int gq[$], fq[$];

  always @(posedge CLK) cyc++;

  task automatic chk(string nm, longint act, longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  // Reference: follow goto, fall back through failure links, count hops.
  task automatic model_accept(int c);
    exp_t e;
    int s, hops, nxt;
    bit done;
    s = m_state; hops = 0; nxt = 0; done = 0;
    while (!done) begin
      if (goto_tbl[s*16 + c] != 8'hFF) begin
        nxt = goto_tbl[s*16 + c]; done = 1;
      end else if (s == 0) begin
        nxt = 0; done = 1;
      end else begin
        hops++;
        if (hops == MAXF) begin m_err = 1; s = 0; end
        else s = fail_tbl[s];
      end
    end
    m_state = nxt;
    e.st = nxt; e.m = acc_tbl[nxt]; e.pos = m_pos; e.lat = 5 + 4*hops;
    e.err = m_err; e.acc_cyc = cyc;
    m_pos = (m_pos + 1) % 65536;
    expq.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (GOTO_RE) gq.push_back(ADDR_G);
      if (FAIL_RE) fq.push_back(ADDR_F);
    end
  end

  always @(negedge CLK) begin
    if (!RST && chk_on) begin
      chk("one_strobe", int'(GOTO_RE) + int'(FAIL_RE) + int'(ACC_RE) <= 1, 1);
      if (CHARA_VALID && CHARA_READY) model_accept(int'(CHARA));
      if (OUT_VALID) begin
        chk("out_has_exp", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          chk("now_state", NOW_STATE, expq[0].st);
          chk("match", MATCH, expq[0].m);
          chk("pos", POS, expq[0].pos);
          chk("fail_err", FAIL_ERR, expq[0].err);
          chk("ready_low_emit", CHARA_READY, 0);
          if (!prev_ov) begin
            cur_lat = cyc - expq[0].acc_cyc;
            chk("latency", cur_lat, expq[0].lat);
          end
          if (OUT_READY) begin
            last_st = NOW_STATE; last_m = MATCH; last_pos = POS; last_lat = cur_lat;
            void'(expq.pop_front());
          end
        end
      end
      prev_ov = OUT_VALID;
    end
  end

  task automatic send(int c);
    bit got;
    got = 0;
    @(posedge CLK); #1;
    CHARA = 4'(c); CHARA_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (CHARA_READY) begin got = 1; break; end
    end
    chk("accept_in_time", got, 1);
    @(posedge CLK); #1;
    CHARA_VALID = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (expq.size() == 0 && !OUT_VALID) break;
    end
    chk("drained", expq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit seen;
    for (int i = 0; i < 4096; i++) goto_tbl[i] = 8'hFF;
    for (int i = 0; i < 256; i++) begin fail_tbl[i] = 8'h00; acc_tbl[i] = 1'b0; end
    RST = 1; EN = 0; CHARA_VALID = 0; CHARA = 0; OUT_READY = 1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_now_state", NOW_STATE, 0);
    chk("rst_pos", POS, 0);
    chk("rst_fail_err", FAIL_ERR, 0);
    chk("rst_strobes", {GOTO_RE, FAIL_RE, ACC_RE}, 0);
    chk("rst_addr_g", ADDR_G, 0);
    RST = 0; EN = 1; chk_on = 1;
    @(negedge CLK);
    chk("idle_ready", CHARA_READY, 1);

    // Goto hit from root
    goto_tbl[12'h003] = 8'h05; acc_tbl[5] = 1'b1;
    send(3); wait_done();
    chk("t1_state", last_st, 5); chk("t1_match", last_m, 1);
    chk("t1_pos", last_pos, 0);  chk("t1_lat", last_lat, 5);

    // One failure hop from state 7
    goto_tbl[12'h051] = 8'h07;
    send(1); wait_done();
    chk("t2_pre_state", last_st, 7);
    goto_tbl[12'h022] = 8'h09; fail_tbl[7] = 8'h02;
    gq.delete(); fq.delete();
    send(2); wait_done();
    chk("t2_ngoto", gq.size(), 2);
    chk("t2_addr_g0", gq[0], 12'h072);
    chk("t2_addr_g1", gq[1], 12'h022);
    chk("t2_nfail", fq.size(), 1);
    chk("t2_addr_f", fq[0], 7);
    chk("t2_state", last_st, 9); chk("t2_lat", last_lat, 9);

    // Fall back to root, then a root miss
    fail_tbl[9] = 8'h00;
    send(4); wait_done();
    chk("t3_pre_state", last_st, 0);
    fq.delete();
    send(5); wait_done();
    chk("t3_nfail", fq.size(), 0);
    chk("t3_state", last_st, 0); chk("t3_match", last_m, 0);
    chk("t3_lat", last_lat, 5);

    // Backpressure
    OUT_READY = 0;
    send(3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (OUT_VALID) begin seen = 1; break; end
    end
    chk("t4_out_valid", seen, 1);
    repeat (3) begin
      @(negedge CLK);
      chk("t4_hold_valid", OUT_VALID, 1);
      chk("t4_hold_state", NOW_STATE, 5);
      chk("t4_hold_pos", POS, 5);
    end
    @(posedge CLK); #1; OUT_READY = 1;
    wait_done();
    chk("t4_pos", last_pos, 5);
    chk("t4_pos_after", POS, 6);

    // Failure chain that never resolves
    fail_tbl[5] = 8'h06; fail_tbl[6] = 8'h05;
    send(7); wait_done();
    chk("t5_fail_err", FAIL_ERR, 1);
    chk("t5_state", last_st, 0);
    chk("t5_lat", last_lat, 69);
    chk("t5_pos", last_pos, 6);

    // EN low blocks new characters
    EN = 0; CHARA_VALID = 1; CHARA = 3; cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (CHARA_READY || OUT_VALID) cnt++;
    end
    chk("t6_en_low", cnt, 0);
    @(posedge CLK); #1; CHARA_VALID = 0; EN = 1;

    // Reset while waiting on the failure RAM
    goto_tbl[12'h008] = 8'h01; fail_tbl[1] = 8'h00;
    send(8); wait_done();
    send(9);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (FAIL_RE) begin seen = 1; break; end
    end
    chk("t6_fail_re", seen, 1);
    @(posedge CLK); #2;
    RST = 1; chk_on = 0;
    #1;
    chk("t6_rst_out_valid", OUT_VALID, 0);
    chk("t6_rst_pos", POS, 0);
    chk("t6_rst_fail_err", FAIL_ERR, 0);
    chk("t6_rst_addr_f", ADDR_F, 0);
    chk("t6_rst_addr_g", ADDR_G, 0);
    chk("t6_rst_strobes", {GOTO_RE, FAIL_RE, ACC_RE}, 0);
    expq.delete(); m_state = 0; m_pos = 0; m_err = 0; prev_ov = 0;
    @(posedge CLK); #1; RST = 0; chk_on = 1;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (OUT_VALID) cnt++;
    end
    chk("t6_no_result", cnt, 0);
    send(3); wait_done();
    chk("t6_pos_restart", last_pos, 0);
    chk("t6_state_restart", last_st, 5);

    // Randomized tables and traffic over states 0..15
    for (int s = 0; s < 16; s++) begin
      for (int c = 0; c < 16; c++)
        goto_tbl[s*16 + c] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'hFF;
      fail_tbl[s] = (s == 0) ? 8'h00 : 8'($urandom_range(0, 15));
      acc_tbl[s]  = 1'($urandom_range(0, 1));
    end
    repeat (3000) begin
      @(posedge CLK); #1;
      CHARA_VALID = 1'($urandom_range(0, 1));
      CHARA       = 4'($urandom_range(0, 15));
      EN          = ($urandom_range(0, 7) != 0);
      OUT_READY   = ($urandom_range(0, 3) != 0);
    end
    CHARA_VALID = 0; EN = 1; OUT_READY = 1;
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
